// File: rtl/exe_mem_stage.sv
// -----------------------------------------------------------------------------
// exe_mem_stage
//   Execute stage followed by the EXE/MEM pipeline register. Takes the outputs
//   of the ID/EXE register, runs the ALU, resolves conditional branches and
//   jal, and registers the result plus memory/writeback control for MEM.
//
//   Build option:
//     EXE_MUL_EN  defined   : opcode 111 is MUL, computed by an iterative
//                             shift-add multiplier that stalls the upstream
//                             pipe (PC, IF/ID, ID/EXE) while it runs.
//                 undefined : opcode 111 is SRL, single-cycle; stall tied 0.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     valid_in                      ID/EXE holds a real instruction
//     wen_in, mem_to_reg_in,
//     mem_write_in, mem_read_in     control from ID/EXE
//     branch_in, jal_in             branch (taken on alu_in1==alu_in2) / jal
//     nPC_in, PC_jal_in             PC+1 (link value) / jal target
//     imm_extended_in               branch offset
//     alu_in1, alu_in2, rdata2_in   operands / store data
//     opcode_in, waddr_in           ALU op / destination register
//     stall                         combinational upstream hold
//     pc_sel, pc_target             registered one-cycle redirect
//     valid_out .. waddr_out        EXE/MEM register contents
// -----------------------------------------------------------------------------
module exe_mem_stage #(
  parameter int DSIZE = 32,
  parameter int ISIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             wen_in,
  input  logic             mem_to_reg_in,
  input  logic             mem_write_in,
  input  logic             mem_read_in,
  input  logic             branch_in,
  input  logic             jal_in,
  input  logic [ISIZE-1:0] nPC_in,
  input  logic [ISIZE-1:0] PC_jal_in,
  input  logic [DSIZE-1:0] imm_extended_in,
  input  logic [DSIZE-1:0] alu_in1,
  input  logic [DSIZE-1:0] alu_in2,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [2:0]       opcode_in,
  input  logic [ASIZE-1:0] waddr_in,
  output logic             stall,
  output logic             pc_sel,
  output logic [ISIZE-1:0] pc_target,
  output logic             valid_out,
  output logic             wen_out,
  output logic             mem_to_reg_out,
  output logic             mem_write_out,
  output logic             mem_read_out,
  output logic [DSIZE-1:0] alu_result_out,
  output logic [DSIZE-1:0] rdata2_out,
  output logic [ASIZE-1:0] waddr_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_X7  = 3'b111;

  // EXE/MEM register
  logic             pc_sel_q;
  logic [ISIZE-1:0] pc_target_q;
  logic             valid_q;
  logic             wen_q;
  logic             mem_to_reg_q;
  logic             mem_write_q;
  logic             mem_read_q;
  logic [DSIZE-1:0] result_q;
  logic [DSIZE-1:0] rdata2_q;
  logic [ASIZE-1:0] waddr_q;

  // Next-state values for an ordinary single-cycle instruction
  logic             squash;
  logic             taken_d;
  logic [ISIZE-1:0] target_d;
  logic [DSIZE-1:0] link;
  logic [DSIZE-1:0] alu_d;
  logic [DSIZE-1:0] result_d;

  always_comb begin
    // The instruction behind a redirect is on the wrong path.
    squash   = ~valid_in | pc_sel_q;
    taken_d  = ~squash & ((branch_in & (alu_in1 == alu_in2)) | jal_in);
    target_d = jal_in ? PC_jal_in : (nPC_in + imm_extended_in[ISIZE-1:0]);

    link             = '0;
    link[ISIZE-1:0]  = nPC_in;

    alu_d = '0;
    case (opcode_in)
      OP_ADD: alu_d = alu_in1 + alu_in2;
      OP_SUB: alu_d = alu_in1 - alu_in2;
      OP_AND: alu_d = alu_in1 & alu_in2;
      OP_OR:  alu_d = alu_in1 | alu_in2;
      OP_XOR: alu_d = alu_in1 ^ alu_in2;
      OP_SLT: alu_d = ($signed(alu_in1) < $signed(alu_in2)) ? DSIZE'(1) : '0;
      OP_SLL: alu_d = alu_in1 << alu_in2[4:0];
`ifdef EXE_MUL_EN
      // Product comes from the multiplier FSM, not from this path.
      OP_X7:  alu_d = '0;
`else
      OP_X7:  alu_d = alu_in1 >> alu_in2[4:0];
`endif
      default: alu_d = '0;
    endcase

    result_d = jal_in ? link : alu_d;
  end

`ifdef EXE_MUL_EN
  // state    | meaning
  // IDLE     | normal single-cycle flow; a live opcode 111 starts a multiply
  // MUL_BUSY | one shift-add step per cycle, bubbles into EXE/MEM, stall=1
  // MUL_DONE | product ready; next edge writes it with the held controls
  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

  localparam int CW = $clog2(DSIZE);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [DSIZE-1:0] mcand_q;
  logic [DSIZE-1:0] mplier_q;
  logic [DSIZE-1:0] prod_q;
  logic             h_wen_q;
  logic             h_m2r_q;
  logic             h_mw_q;
  logic             h_mr_q;
  logic [DSIZE-1:0] h_rdata2_q;
  logic [ASIZE-1:0] h_waddr_q;
  logic             mul_start;

  assign mul_start = (state_q == IDLE) & ~squash & (opcode_in == OP_X7);
  assign stall     = mul_start | (state_q == MUL_BUSY);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_sel_q     <= 1'b0;
      pc_target_q  <= '0;
      valid_q      <= 1'b0;
      wen_q        <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      result_q     <= '0;
      rdata2_q     <= '0;
      waddr_q      <= '0;
`ifdef EXE_MUL_EN
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      h_wen_q      <= 1'b0;
      h_m2r_q      <= 1'b0;
      h_mw_q       <= 1'b0;
      h_mr_q       <= 1'b0;
      h_rdata2_q   <= '0;
      h_waddr_q    <= '0;
`endif
    end else begin
      // Ordinary load; bubbles keep data fields but clear every side effect.
      pc_sel_q     <= taken_d;
      if (taken_d) pc_target_q <= target_d;
      valid_q      <= ~squash;
      wen_q        <= wen_in & ~squash;
      mem_to_reg_q <= mem_to_reg_in;
      mem_write_q  <= mem_write_in & ~squash;
      mem_read_q   <= mem_read_in & ~squash;
      result_q     <= result_d;
      rdata2_q     <= rdata2_in;
      waddr_q      <= waddr_in;
`ifdef EXE_MUL_EN
      // Later assignments below override the ordinary load while multiplying.
      case (state_q)
        IDLE: begin
          if (mul_start) begin
            pc_sel_q    <= 1'b0;
            valid_q     <= 1'b0;
            wen_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mcand_q     <= alu_in1;
            mplier_q    <= alu_in2;
            prod_q      <= '0;
            cnt_q       <= CW'(DSIZE - 1);
            h_wen_q     <= wen_in;
            h_m2r_q     <= mem_to_reg_in;
            h_mw_q      <= mem_write_in;
            h_mr_q      <= mem_read_in;
            h_rdata2_q  <= rdata2_in;
            h_waddr_q   <= waddr_in;
            state_q     <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          pc_sel_q    <= 1'b0;
          valid_q     <= 1'b0;
          wen_q       <= 1'b0;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == '0) state_q <= MUL_DONE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        MUL_DONE: begin
          // Upstream still presents the multiply here; it advances on this edge.
          pc_sel_q     <= 1'b0;
          valid_q      <= 1'b1;
          wen_q        <= h_wen_q;
          mem_to_reg_q <= h_m2r_q;
          mem_write_q  <= h_mw_q;
          mem_read_q   <= h_mr_q;
          result_q     <= prod_q;
          rdata2_q     <= h_rdata2_q;
          waddr_q      <= h_waddr_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`endif
    end
  end

  assign pc_sel         = pc_sel_q;
  assign pc_target      = pc_target_q;
  assign valid_out      = valid_q;
  assign wen_out        = wen_q;
  assign mem_to_reg_out = mem_to_reg_q;
  assign mem_write_out  = mem_write_q;
  assign mem_read_out   = mem_read_q;
  assign alu_result_out = result_q;
  assign rdata2_out     = rdata2_q;
  assign waddr_out      = waddr_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
module tb_exe_mem_stage;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, OP7 = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, wen_in, mem_to_reg_in, mem_write_in, mem_read_in;
  logic        branch_in, jal_in;
  logic [31:0] nPC_in, PC_jal_in, imm_extended_in, alu_in1, alu_in2, rdata2_in;
  logic [2:0]  opcode_in;
  logic [4:0]  waddr_in;
  logic        stall, pc_sel;
  logic [31:0] pc_target;
  logic        valid_out, wen_out, mem_to_reg_out, mem_write_out, mem_read_out;
  logic [31:0] alu_result_out, rdata2_out;
  logic [4:0]  waddr_out;

  exe_mem_stage #(.DSIZE(32), .ISIZE(32), .ASIZE(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .wen_in(wen_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .mem_read_in(mem_read_in), .branch_in(branch_in), .jal_in(jal_in),
    .nPC_in(nPC_in), .PC_jal_in(PC_jal_in), .imm_extended_in(imm_extended_in),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .rdata2_in(rdata2_in),
    .opcode_in(opcode_in), .waddr_in(waddr_in), .stall(stall), .pc_sel(pc_sel),
    .pc_target(pc_target), .valid_out(valid_out), .wen_out(wen_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .mem_read_out(mem_read_out), .alu_result_out(alu_result_out),
    .rdata2_out(rdata2_out), .waddr_out(waddr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        val, wen, m2r, mw, mr, br, jal;
    logic [2:0]  op;
    logic [31:0] a, b, rd2, npc, pcjal, imm;
    logic [4:0]  wa;
    logic [5:0]  ectl;   // {valid, wen, m2r, mw, mr, pc_sel}
    logic [31:0] etgt, eres;
    bit          chk;    // compare data fields too
  } vec_t;

  typedef struct {
    string       name;
    logic [5:0]  ctl;
    logic [31:0] tgt, res, rd2;
    logic [4:0]  wa;
    bit          chk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(logic val, logic wen, logic m2r, logic mw, logic mr,
                             logic br, logic jal, logic [2:0] op, logic [31:0] a,
                             logic [31:0] b, logic [31:0] rd2, logic [31:0] npc,
                             logic [31:0] pcjal, logic [31:0] imm, logic [4:0] wa,
                             logic [5:0] ectl, logic [31:0] etgt, logic [31:0] eres,
                             bit chk);
    vec_t t;
    t.val = val; t.wen = wen; t.m2r = m2r; t.mw = mw; t.mr = mr; t.br = br;
    t.jal = jal; t.op = op; t.a = a; t.b = b; t.rd2 = rd2; t.npc = npc;
    t.pcjal = pcjal; t.imm = imm; t.wa = wa; t.ectl = ectl; t.etgt = etgt;
    t.eres = eres; t.chk = chk;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t t);
    valid_in = t.val; wen_in = t.wen; mem_to_reg_in = t.m2r; mem_write_in = t.mw;
    mem_read_in = t.mr; branch_in = t.br; jal_in = t.jal; opcode_in = t.op;
    alu_in1 = t.a; alu_in2 = t.b; rdata2_in = t.rd2; nPC_in = t.npc;
    PC_jal_in = t.pcjal; imm_extended_in = t.imm; waddr_in = t.wa;
  endtask

  task automatic idle_in();
    drive(v(0,0,0,0,0,0,0,ADD,0,0,0,0,0,0,0,6'b0,0,0,0));
  endtask

  task automatic push(input string nm, input vec_t t);
    exp_t e;
    e.name = nm; e.ctl = t.ectl; e.tgt = t.etgt; e.res = t.eres;
    e.rd2 = t.rd2; e.wa = t.wa; e.chk = t.chk;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".valid"}, 32'(valid_out), 32'(e.ctl[5]));
    chk({e.name, ".wen"},   32'(wen_out),   32'(e.ctl[4]));
    chk({e.name, ".mw"},    32'(mem_write_out), 32'(e.ctl[2]));
    chk({e.name, ".mr"},    32'(mem_read_out),  32'(e.ctl[1]));
    chk({e.name, ".pcsel"}, 32'(pc_sel),    32'(e.ctl[0]));
    if (e.ctl[0]) chk({e.name, ".tgt"}, pc_target, e.tgt);
    if (e.chk) begin
      chk({e.name, ".m2r"}, 32'(mem_to_reg_out), 32'(e.ctl[3]));
      chk({e.name, ".res"}, alu_result_out, e.res);
      chk({e.name, ".rd2"}, rdata2_out, e.rd2);
      chk({e.name, ".wa"},  32'(waddr_out), 32'(e.wa));
    end
  endtask

  // Drive one instruction, check stall, clock it, compare the EXE/MEM result.
  task automatic step(input string nm, input vec_t t, input logic exp_stall);
    drive(t);
    push(nm, t);
    #1 chk({nm, ".stall"}, 32'(stall), 32'(exp_stall));
    @(posedge clk); #1;
    compare();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"}, 32'(valid_out), 0);
    chk({nm, ".wen"},   32'(wen_out), 0);
    chk({nm, ".m2r"},   32'(mem_to_reg_out), 0);
    chk({nm, ".mw"},    32'(mem_write_out), 0);
    chk({nm, ".mr"},    32'(mem_read_out), 0);
    chk({nm, ".pcsel"}, 32'(pc_sel), 0);
    chk({nm, ".tgt"},   pc_target, 0);
    chk({nm, ".res"},   alu_result_out, 0);
    chk({nm, ".rd2"},   rdata2_out, 0);
    chk({nm, ".wa"},    32'(waddr_out), 0);
    chk({nm, ".stall"}, 32'(stall), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();

    //            val wen m2r mw mr br jal op  a            b            rd2          npc pcjal imm          wa  ectl      tgt res          chk
    vecs.push_back(v(1,1,0,0,0,0,0,ADD, 7,           5,           0,           0,  0,    0,           3, 6'b110000, 0,  12,          1));
    vecs.push_back(v(1,1,0,0,0,0,0,SUB, 0,           1,           0,           0,  0,    0,           4, 6'b110000, 0,  32'hFFFFFFFF,1));
    vecs.push_back(v(1,1,0,0,0,0,0,AND_,32'hF0F0,    32'hFF00,    0,           0,  0,    0,           5, 6'b110000, 0,  32'hF000,    1));
    vecs.push_back(v(1,1,0,0,0,0,0,OR_, 32'hF0F0,    32'h0F0F,    0,           0,  0,    0,           6, 6'b110000, 0,  32'hFFFF,    1));
    vecs.push_back(v(1,1,0,0,0,0,0,XOR_,32'hAAAA,    32'hFFFF,    0,           0,  0,    0,           7, 6'b110000, 0,  32'h5555,    1));
    vecs.push_back(v(1,1,0,0,0,0,0,SLT, 32'hFFFFFFFF,1,           0,           0,  0,    0,           8, 6'b110000, 0,  1,           1));
    vecs.push_back(v(1,1,0,0,0,0,0,SLT, 1,           32'hFFFFFFFF,0,           0,  0,    0,           9, 6'b110000, 0,  0,           1));
    vecs.push_back(v(1,1,0,0,0,0,0,SLL, 1,           31,          0,           0,  0,    0,           10,6'b110000, 0,  32'h80000000,1));
    vecs.push_back(v(1,1,0,0,0,0,0,SLL, 3,           32'h21,      0,           0,  0,    0,           11,6'b110000, 0,  6,           1));
    vecs.push_back(v(1,0,0,1,0,0,0,ADD, 100,         4,           32'hDEADBEEF,0,  0,    0,           0, 6'b100100, 0,  104,         1));
    vecs.push_back(v(1,1,1,0,1,0,0,ADD, 200,         8,           0,           0,  0,    0,           12,6'b111010, 0,  208,         1));
    vecs.push_back(v(0,1,1,1,1,0,0,ADD, 1,           1,           0,           0,  0,    0,           13,6'b000000, 0,  0,           0));
    vecs.push_back(v(1,0,0,0,0,1,0,SUB, 4,           4,           0,           10, 0,    5,           0, 6'b100001, 15, 0,           1));
    vecs.push_back(v(1,1,0,1,0,0,0,ADD, 1,           2,           0,           0,  0,    0,           14,6'b000000, 0,  0,           0));
    vecs.push_back(v(1,0,0,0,0,1,0,SUB, 4,           5,           0,           10, 0,    5,           0, 6'b100000, 0,  32'hFFFFFFFF,1));
    vecs.push_back(v(1,1,0,0,0,0,1,ADD, 9,           9,           0,           20, 100,  0,           1, 6'b110001, 100,20,          1));
    vecs.push_back(v(1,1,0,0,0,1,0,SUB, 4,           4,           0,           30, 0,    2,           2, 6'b000000, 0,  0,           0));
    vecs.push_back(v(1,1,0,0,0,0,0,ADD, 2,           3,           0,           0,  0,    0,           15,6'b110000, 0,  5,           1));
    vecs.push_back(v(1,0,0,0,0,1,0,ADD, 7,           7,           0,           50, 0,    32'hFFFFFFF8,0, 6'b100001, 42, 14,          1));
    vecs.push_back(v(1,1,0,0,0,0,0,ADD, 8,           8,           0,           0,  0,    0,           16,6'b000000, 0,  0,           0));
    vecs.push_back(v(0,0,0,0,0,1,0,ADD, 4,           4,           0,           10, 0,    5,           0, 6'b000000, 0,  0,           0));
    vecs.push_back(v(1,1,0,0,0,0,0,ADD, 6,           6,           0,           0,  0,    0,           17,6'b110000, 0,  12,          1));
`ifndef EXE_MUL_EN
    vecs.push_back(v(1,1,0,0,0,0,0,OP7, 32'h80,      4,           0,           0,  0,    0,           18,6'b110000, 0,  32'h8,       1));
    vecs.push_back(v(1,1,0,0,0,0,0,OP7, 32'h80000000,32'h24,      0,           0,  0,    0,           19,6'b110000, 0,  32'h08000000,1));
`endif

    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i], 1'b0);

`ifdef EXE_MUL_EN
    begin : mul_seq
      int n;
      n = 0;
      drive(v(1,1,0,0,0,0,0,OP7,6,7,32'h55,0,0,0,9,6'b0,0,0,0));
      #1;
      for (int k = 0; k < 100; k++) begin
        if (!stall) break;
        n++;
        @(posedge clk); #1;
        chk($sformatf("mul.bubble%0d", k), 32'(valid_out | wen_out), 0);
      end
      chk("mul.stall_cycles", n, 33);
      @(posedge clk); #1;
      chk("mul.res", alu_result_out, 42);
      chk("mul.valid", 32'(valid_out), 1);
      chk("mul.wen", 32'(wen_out), 1);
      chk("mul.wa", 32'(waddr_out), 9);
      chk("mul.rd2", rdata2_out, 32'h55);
      step("after_mul", v(1,1,0,0,0,0,0,ADD,2,2,0,0,0,0,3,6'b110000,0,4,1), 1'b0);
    end

    // Opcode 111 behind a redirect, or as a bubble, must not start a multiply.
    step("beq_pre_mul", v(1,0,0,0,0,1,0,ADD,1,1,0,10,0,5,0,6'b100001,15,2,1), 1'b0);
    step("mul_squashed", v(1,1,0,0,0,0,0,OP7,6,7,0,0,0,0,4,6'b000000,0,0,0), 1'b0);
    step("mul_bubble", v(0,1,0,0,0,0,0,OP7,6,7,0,0,0,0,4,6'b000000,0,0,0), 1'b0);

    drive(v(1,1,0,0,0,0,0,OP7,3,5,0,0,0,0,6,6'b0,0,0,0));
    #1 chk("rstmul.stall0", 32'(stall), 1);
    repeat (22) @(posedge clk);
    #1 chk("rstmul.busy", 32'(stall), 1);
`else
    drive(v(1,1,0,0,0,0,0,ADD,9,9,0,0,0,0,6,6'b0,0,0,0));
    #1;
`endif
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    chk_zero("rst_mid");
    rst = 1'b0;
    step("add_after_rst", v(1,1,0,0,0,0,0,ADD,1,1,0,0,0,0,2,6'b110000,0,2,1), 1'b0);

    idle_in();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
